freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measures an incoming slow square wave, such as a divided clock or an external tick, in i_clk_FPGA cycles.
- Reports the period and the high time of each complete cycle, with a one-cycle valid strobe.
- Flags loss of signal with a timeout.
- Sits on the receive side of divided-clock paths: board self-test, and checking divider outputs against expected counts.

Parameters:
- CNT_W, 32, width of the period and high-time counters/outputs.
- TIMEOUT, 100_000_000, cycles without a rising edge before declaring loss of signal; must satisfy TIMEOUT <= 2^CNT_W - 1.
- SYNC_STAGES, 2, flip-flops in the i_sig synchronizer; minimum 2.

Ports:
- i_clk_FPGA  input  1  system clock.
- i_reset  input  1  reset.
- i_enable  input  1  measurement enable; level sensitive.
- i_sig  input  1  asynchronous signal under measurement.
- o_period  output  CNT_W  cycles between the last two rising edges of i_sig.
- o_high  output  CNT_W  cycles from a rising edge to the following falling edge.
- o_valid  output  1  one-cycle pulse when o_period/o_high update.
- o_timeout  output  1  sticky loss-of-signal flag.
- o_busy  output  1  high in states ARM and MEASURE.

Behaviour:
- Interface (already decided): reset i_reset, asynchronous, active-low; clock i_clk_FPGA.
- Reset: all outputs 0, synchronizer and edge register 0, counters 0, state IDLE. Asserting reset at any point, including mid-measurement, aborts immediately with no o_valid.
- Synchronizer: i_sig passes through SYNC_STAGES flops. A registered copy of the last stage gives rise = s & ~s_d and fall = ~s & s_d.
- Only synchronized edges are used; raw i_sig is never used in logic.
- State IDLE: counters held at 0. On i_enable=1, go to ARM.
- State ARM: wait for rise. On rise: r_cnt <= 1, r_high_seen <= 0, go to MEASURE. No output update.
- State MEASURE: r_cnt increments by 1 each cycle.
  - On fall with r_high_seen=0: latch r_high <= r_cnt, set r_high_seen.
  - On rise: o_period <= r_cnt, o_high <= r_high, o_valid <= 1 for one cycle, o_timeout <= 0, r_cnt <= 1, r_high_seen <= 0. Remain in MEASURE.
- Result: if rises are detected at cycles t0 and t1, o_period = t1 - t0 and o_high = tf - t0, where tf is the first fall after t0.
- Latency: o_valid is high SYNC_STAGES+1 cycles after the first i_clk_FPGA edge that samples i_sig high.
- Timeout: in MEASURE, if r_cnt reaches TIMEOUT with no rise, set o_timeout <= 1 and go to ARM. o_period and o_high hold their last values. o_timeout stays high until the next o_valid, i_enable deassertion, or reset.
- No rise, or no fall before the rise: o_high = 0 and o_period is still reported (signal stuck high is not possible here, since a rise requires a preceding fall).
- i_enable=0 in any state: go to IDLE next cycle, no o_valid, o_period and o_high hold, o_timeout cleared.
- Simultaneous rise and timeout in the same cycle: the rise wins (valid reported, no timeout).
- Counter never wraps: the timeout fires before r_cnt reaches 2^CNT_W - 1.
- o_busy = (state != IDLE), registered.

Decomposition:
- Shared package (clk_pkg): meter_state_t enum {IDLE, ARM, MEASURE}; period_t = logic [CNT_W-1:0]; default TIMEOUT constant.
- One natural sub-module: sync_edge_det (parameter SYNC_STAGES; ports i_clk_FPGA, i_reset, i_sig, o_level, o_rise, o_fall). Reusable for other asynchronous inputs.
- FSM and counters stay in freq_meter.

Test Plan:
- Divider loopback: drive i_sig from a clock divider with MAX_COUNT=5, i_enable=1 -> o_valid every 10 cycles; o_period=10, o_high=5; o_timeout=0.
- Asymmetric wave: i_sig high 3 cycles, low 7 cycles, repeated -> o_period=10, o_high=3 on every o_valid. First o_valid only after the second synchronized rise.
- Loss of signal: TIMEOUT=50, i_sig held low after valid measurements -> o_timeout=1 exactly 50 cycles after the last rise; o_period keeps 10; state ARM. Restart the wave -> o_timeout clears at the next o_valid.
- Enable drop mid-measure: deassert i_enable 4 cycles after a rise -> no o_valid; o_busy=0 next cycle; outputs hold. Re-enable -> the first o_valid needs two new rises.
- Reset mid-measure: pull i_reset low asynchronously between clock edges -> all outputs 0 immediately; after release, state IDLE with no spurious o_valid.
- Boundary: period exactly 2 cycles (high 1, low 1) with SYNC_STAGES=2 -> o_period=2, o_high=1; a rise on the timeout cycle reports valid with o_timeout=0.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared types and defaults for the frequency/period measurement blocks.
package clk_pkg;

  localparam int          DEFAULT_CNT_W       = 32;
  localparam int unsigned DEFAULT_TIMEOUT     = 100_000_000;
  localparam int          DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_t;

  typedef logic [DEFAULT_CNT_W-1:0] period_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered rise/fall
// strobes derived from the synchronized level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_FPGA,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_dly_q;
  logic                   rise_q;
  logic                   fall_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
    if (!i_reset) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], i_sig};
      level_dly_q <= sync_q[SYNC_STAGES-1];
      rise_q      <= sync_q[SYNC_STAGES-1] & ~level_dly_q;
      fall_q      <= ~sync_q[SYNC_STAGES-1] & level_dly_q;
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow square wave in i_clk_FPGA cycles,
// with a one-cycle valid strobe and a sticky loss-of-signal flag.
module freq_meter
  import clk_pkg::*;
#(
  parameter int          CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int          SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             i_clk_FPGA,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic sig_rise;
  logic sig_fall;
  logic sig_level_unused;  // edges carry all timing; the level is not needed here

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk_FPGA(i_clk_FPGA),
    .i_reset   (i_reset),
    .i_sig     (i_sig),
    .o_level   (sig_level_unused),
    .o_rise    (sig_rise),
    .o_fall    (sig_fall)
  );

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             high_seen_q, high_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_out_q, high_out_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_d      = high_q;
    high_seen_d = high_seen_q;
    period_d    = period_q;
    high_out_d  = high_out_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!i_enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      high_d      = '0;
      high_seen_d = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (sig_rise) begin
            cnt_d       = ONE;
            high_d      = '0;
            high_seen_d = 1'b0;
            state_d     = MEASURE;
          end
        end
        MEASURE: begin
          cnt_d = cnt_q + ONE;
          // A rise on the timeout cycle still completes the measurement.
          if (sig_rise) begin
            period_d    = cnt_q;
            high_out_d  = high_seen_q ? high_q : '0;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = ONE;
            high_d      = '0;
            high_seen_d = 1'b0;
          end else begin
            if (sig_fall && !high_seen_q) begin
              high_d      = cnt_q;
              high_seen_d = 1'b1;
            end
            if (cnt_q == TIMEOUT_CNT) begin
              timeout_d = 1'b1;
              cnt_d     = '0;
              state_d   = ARM;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_q      <= '0;
      high_seen_q <= 1'b0;
      period_q    <= '0;
      high_out_q  <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_q      <= high_d;
      high_seen_q <= high_seen_d;
      period_q    <= period_d;
      high_out_q  <= high_out_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_out_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_busy    = busy_q;

endmodule
